// File: rtl/alu_seq_exec_if.sv
// Request/result bundle between the issuing stage, the sequential ALU and its consumer.
// The master drives operations and accepts results; the slave is the execution unit.
interface alu_seq_exec_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, opcode, op1, op2, out_ready,
        input  in_ready, out_valid, out, carry, zero, err
    );

    modport slave (
        input  in_valid, opcode, op1, op2, out_ready,
        output in_ready, out_valid, out, carry, zero, err
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle logic/arithmetic, bit-serial shifts, result and flags held
// until the consumer accepts them.
module alu_seq_exec #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input logic           clk,
    input logic           rst,
    alu_seq_exec_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_XNOR = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;

    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    // Single-cycle result as {illegal, carry, result}; shifts here cover only the zero-count case.
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [3:0]       opc,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] res;
        logic             cy;
        logic             ill;
        wide = {(WIDTH+1){1'b0}};
        res  = {WIDTH{1'b0}};
        cy   = 1'b0;
        ill  = 1'b0;
        case (opc)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            OP_NOT:  res = ~a;
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[WIDTH-1:0];
                cy   = wide[WIDTH];
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                res  = wide[WIDTH-1:0];
                cy   = wide[WIDTH];
            end
            OP_SHL:  res = a;
            OP_SHR:  res = a;
            default: ill = 1'b1;
        endcase
        return {ill, cy, res};
    endfunction

    logic [1:0]       state_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_r;
    logic             carry_r;
    logic             zero_r;
    logic             err_r;
    logic [WIDTH-1:0] shift_r;
    logic [SHW-1:0]   count_r;
    logic             dir_left_r;

    logic [WIDTH+1:0] eval_s;
    logic             is_shift_s;
    logic [SHW-1:0]   k_s;
    logic [WIDTH-1:0] shift_next_s;
    logic             shift_bit_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
    assign bus.carry     = carry_r;
    assign bus.zero      = zero_r;
    assign bus.err       = err_r;

    // Decode and evaluate the operation currently presented by the issuer.
    always_comb begin
        eval_s     = alu_eval(bus.opcode, bus.op1, bus.op2);
        is_shift_s = (bus.opcode == OP_SHL) || (bus.opcode == OP_SHR);
        k_s        = bus.op2[SHW-1:0];
    end

    // One-bit shift step; the bit leaving the register becomes the candidate carry.
    always_comb begin
        if (dir_left_r) begin
            shift_next_s = {shift_r[WIDTH-2:0], 1'b0};
            shift_bit_s  = shift_r[WIDTH-1];
        end else begin
            shift_next_s = {1'b0, shift_r[WIDTH-1:1]};
            shift_bit_s  = shift_r[0];
        end
    end

    // Control FSM together with the result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
            shift_r     <= {WIDTH{1'b0}};
            count_r     <= {SHW{1'b0}};
            dir_left_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        if (is_shift_s && (k_s != {SHW{1'b0}})) begin
                            state_r    <= ST_SHIFT;
                            shift_r    <= bus.op1;
                            count_r    <= k_s;
                            dir_left_r <= (bus.opcode == OP_SHL);
                            err_r      <= 1'b0;
                        end else begin
                            // Illegal opcodes evaluate to a zero result, so zero=1 falls out.
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            out_r       <= eval_s[WIDTH-1:0];
                            carry_r     <= eval_s[WIDTH];
                            zero_r      <= (eval_s[WIDTH-1:0] == {WIDTH{1'b0}});
                            err_r       <= eval_s[WIDTH+1];
                        end
                    end
                end
                ST_SHIFT: begin
                    shift_r <= shift_next_s;
                    count_r <= count_r - CNT_ONE;
                    if (count_r == CNT_ONE) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        out_r       <= shift_next_s;
                        carry_r     <= shift_bit_s;
                        zero_r      <= (shift_next_s == {WIDTH{1'b0}});
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed cases, backpressure, reset abort and
// randomized operations against an arithmetic reference model.
module tb_alu_seq_exec;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_seq_exec_if #(.WIDTH(8), .SHW(3)) bus ();

    alu_seq_exec #(.WIDTH(8), .SHW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] out;
        logic       carry;
        logic       zero;
        logic       err;
        logic [7:0] lat;
    } exp_t;

    // Reference behaviour from the operation definitions, in plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b);
        exp_t r;
        int   ai;
        int   bi;
        int   k;
        int   v;
        ai = int'(a);
        bi = int'(b);
        k  = bi % 8;
        v  = 0;
        r.carry = 1'b0;
        r.err   = 1'b0;
        r.lat   = 8'd1;
        case (opc)
            4'd0: v = ai & bi;
            4'd1: v = ai | bi;
            4'd2: v = ai ^ bi;
            4'd3: v = 255 - (ai ^ bi);
            4'd4: v = 255 - ai;
            4'd5: begin v = ai + bi; r.carry = (v > 255); end
            4'd6: begin v = ai - bi; r.carry = (ai < bi); end
            4'd7: begin
                v = ai * (1 << k);
                r.carry = (k > 0) ? (((ai >> (8 - k)) & 1) == 1) : 1'b0;
                r.lat = 8'(1 + k);
            end
            4'd8: begin
                v = ai >> k;
                r.carry = (k > 0) ? (((ai >> (k - 1)) & 1) == 1) : 1'b0;
                r.lat = 8'(1 + k);
            end
            default: begin v = 0; r.err = 1'b1; end
        endcase
        r.out  = 8'(v & 255);
        r.zero = (r.out == 8'h00);
        return r;
    endfunction

    // Issue one op, then wait (bounded) for out_valid; lat counts cycles after the accept edge.
    task automatic send(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        bus.opcode   = opc;
        bus.op1      = a;
        bus.op2      = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.opcode   = 4'($urandom);
        bus.op1      = 8'($urandom);
        bus.op2      = 8'($urandom);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== 8'h00 ||
            bus.carry !== 1'b0 || bus.zero !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b out=%h c=%b z=%b e=%b, required 0 1 00 0 0 0",
                     bus.out_valid, bus.in_ready, bus.out, bus.carry, bus.zero, bus.err);
        end
    endtask

    task automatic test_directed();
        logic [3:0] opc [10];
        logic [7:0] a   [10];
        logic [7:0] b   [10];
        exp_t       ex  [10];
        int         lat;
        opc[0] = 4'd3; a[0] = 8'hAA; b[0] = 8'hAA; ex[0] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'd1};
        opc[1] = 4'd3; a[1] = 8'hF0; b[1] = 8'h0F; ex[1] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'd1};
        opc[2] = 4'd5; a[2] = 8'hFF; b[2] = 8'h01; ex[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd1};
        opc[3] = 4'd6; a[3] = 8'h03; b[3] = 8'h05; ex[3] = '{8'hFE, 1'b1, 1'b0, 1'b0, 8'd1};
        opc[4] = 4'd7; a[4] = 8'h81; b[4] = 8'h03; ex[4] = '{8'h08, 1'b0, 1'b0, 1'b0, 8'd4};
        opc[5] = 4'd8; a[5] = 8'h81; b[5] = 8'h01; ex[5] = '{8'h40, 1'b1, 1'b0, 1'b0, 8'd2};
        opc[6] = 4'hC; a[6] = 8'h12; b[6] = 8'h34; ex[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'd1};
        opc[7] = 4'd0; a[7] = 8'hFF; b[7] = 8'h3C; ex[7] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'd1};
        opc[8] = 4'd7; a[8] = 8'h5A; b[8] = 8'h08; ex[8] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'd1};
        opc[9] = 4'd4; a[9] = 8'h0F; b[9] = 8'h77; ex[9] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'd1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(opc[i], a[i], b[i], lat);
            checks++;
            if (lat != int'(ex[i].lat) || bus.out !== ex[i].out || bus.carry !== ex[i].carry ||
                bus.zero !== ex[i].zero || bus.err !== ex[i].err) begin
                errors++;
                $display("FAIL directed[%0d]: lat=%0d out=%h c=%b z=%b e=%b, required lat=%0d out=%h c=%b z=%b e=%b",
                         i, lat, bus.out, bus.carry, bus.zero, bus.err,
                         ex[i].lat, ex[i].out, ex[i].carry, ex[i].zero, ex[i].err);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== ex[i].out) begin
                errors++;
                $display("FAIL directed_release[%0d]: valid=%b ready=%b out=%h, required 0 1 %h",
                         i, bus.out_valid, bus.in_ready, bus.out, ex[i].out);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.out_ready = 1'b0;
        send(4'd2, 8'h0F, 8'hFF, lat);
        checks++;
        if (lat != 1 || bus.out !== 8'hF0) begin
            errors++;
            $display("FAIL bp_result: lat=%0d out=%h, required 1 f0", lat, bus.out);
        end
        bus.in_valid = 1'b1;
        bus.opcode   = 4'd5;
        bus.op1      = 8'h11;
        bus.op2      = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out !== 8'hF0 ||
                bus.zero !== 1'b0 || bus.carry !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b out=%h, required 1 0 f0",
                         i, bus.out_valid, bus.in_ready, bus.out);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== 8'hF0) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b out=%h, required 0 1 f0",
                     bus.out_valid, bus.in_ready, bus.out);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 8'hF0) begin
            errors++;
            $display("FAIL bp_ignored_op: valid=%b out=%h, required 0 f0", bus.out_valid, bus.out);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        // Abort a long shift two cycles in.
        @(negedge clk);
        bus.opcode   = 4'd7;
        bus.op1      = 8'h81;
        bus.op2      = 8'h07;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 8'h00 || bus.in_ready !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL rst_shift: valid=%b out=%h ready=%b err=%b, required 0 00 1 0",
                     bus.out_valid, bus.out, bus.in_ready, bus.err);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_shift_no_result: valid cycles=%0d, required 0", seen);
        end
        // Abort a stalled illegal result; err must clear too.
        bus.out_ready = 1'b0;
        send(4'hF, 8'h01, 8'h02, seen);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.err !== 1'b0 || bus.zero !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_done: valid=%b err=%b zero=%b ready=%b, required 0 0 0 1",
                     bus.out_valid, bus.err, bus.zero, bus.in_ready);
        end
    endtask

    task automatic test_random();
        logic [3:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        exp_t       ex;
        int         lat;
        int         stall;
        for (int n = 0; n < 60; n++) begin
            opc   = 4'($urandom_range(0, 15));
            a     = 8'($urandom);
            b     = 8'($urandom);
            stall = int'($urandom_range(0, 3));
            ex    = model(opc, a, b);
            bus.out_ready = (stall == 0);
            send(opc, a, b, lat);
            checks++;
            if (lat != int'(ex.lat) || bus.out !== ex.out || bus.carry !== ex.carry ||
                bus.zero !== ex.zero || bus.err !== ex.err) begin
                errors++;
                $display("FAIL random[%0d] op=%h a=%h b=%h: lat=%0d out=%h c=%b z=%b e=%b, required lat=%0d out=%h c=%b z=%b e=%b",
                         n, opc, a, b, lat, bus.out, bus.carry, bus.zero, bus.err,
                         ex.lat, ex.out, ex.carry, ex.zero, ex.err);
            end
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                #1;
                checks++;
                if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out !== ex.out) begin
                    errors++;
                    $display("FAIL random_hold[%0d]: valid=%b ready=%b out=%h, required 1 0 %h",
                             n, bus.out_valid, bus.in_ready, bus.out, ex.out);
                end
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== ex.out) begin
                errors++;
                $display("FAIL random_release[%0d]: valid=%b ready=%b out=%h, required 0 1 %h",
                         n, bus.out_valid, bus.in_ready, bus.out, ex.out);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'd0;
        bus.op1       = 8'h00;
        bus.op2       = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
